isolation_tree_scorer: RTL and testbench

Downstream consumer of the serial-to-byte input buffer. Accepts each byte on the buffer's one-cycle `data_ready` pulse and walks a configurable isolation tree one node per cycle. It then reports the resulting path length and an anomaly flag, and pulses `data_processed` back to the buffer. The node table is written through a simple configuration port, and all scoring is sequential.

---
 rtl/itree_pkg.sv | 39 +++
 rtl/itree_node_table.sv | 39 +++
 rtl/isolation_tree_scorer.sv | 158 +++++++++++++++
 tb/tb_isolation_tree_scorer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itree_pkg.sv
// Shared types and derived-size helpers for the isolation tree scorer.
// Contents:
//   state_t  - scorer FSM state (IDLE / WALK / DONE)
//   node_t   - one node-table entry {threshold, leaf, adj}
//   node_count/addr_w/path_w - sizes derived from tree depth and adj width
package itree_pkg;

    // node_t fields are sized by these widths. The top-level DATA_WIDTH and
    // ADJ_W parameters default to them and must stay equal to them.
    localparam int ITREE_DATA_W = 8;
    localparam int ITREE_ADJ_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ITREE_DATA_W-1:0] threshold;
        logic                    leaf;
        logic [ITREE_ADJ_W-1:0]  adj;
    } node_t;

    // A full binary tree of depth D has 2^(D+1)-1 nodes.
    function automatic int node_count(input int depth);
        return (1 << (depth + 1)) - 1;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(node_count(depth));
    endfunction

    // Wide enough for the deepest leaf plus the largest adjustment.
    function automatic int path_w(input int depth, input int adj_w);
        return $clog2(depth + (1 << adj_w));
    endfunction

endpackage

// File: rtl/itree_node_table.sv
// Node table for the isolation tree scorer.
// Holds NODE_COUNT entries, with one synchronous write port and one
// asynchronous read port. Reset clears every entry to
// {threshold=0, leaf=0, adj=0}.
// Ports:
//   clk, reset  - clock; asynchronous active-low reset
//   we          - write strobe (already qualified by the caller)
//   wr_addr     - entry to write, wr_node - data to write
//   rd_addr     - entry to read, rd_node - combinational read data
module itree_node_table
    import itree_pkg::*;
#(
    parameter int NODE_COUNT = 31,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  node_t             wr_node,
    input  logic [ADDR_W-1:0] rd_addr,
    output node_t             rd_node
);

    node_t table_q [NODE_COUNT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                table_q[i] <= '0;
            end
        end else if (we) begin
            table_q[wr_addr] <= wr_node;
        end
    end

    assign rd_node = table_q[rd_addr];

endmodule

// File: rtl/isolation_tree_scorer.sv
// Isolation tree scorer.
// It accepts a sample on the data_ready pulse and then walks the node table
// one node per cycle. When it reaches a leaf it reports the path length and
// an anomaly flag, and pulses data_processed back to the input buffer.
// Ports:
//   clk, reset              - clock; asynchronous active-low reset
//   data_in, data_ready     - sample and its one-cycle valid pulse
//   data_processed          - one-cycle acknowledge to the buffer
//   cfg_we/addr/threshold/leaf/adj - node-table write port
//   cfg_reject              - one-cycle pulse: a write was dropped
//   score_valid             - one-cycle pulse: path_length/anomaly are valid
//   path_length, anomaly    - result, held until the next score
//   busy                    - the FSM is not in IDLE
//   overrun                 - sticky: a sample arrived while busy and was dropped
//
// state | meaning
// IDLE  | waiting for data_ready; configuration writes accepted
// WALK  | visiting one node per cycle until a leaf or the maximum depth
// DONE  | score_valid/data_processed pulse; returns to IDLE
module isolation_tree_scorer
    import itree_pkg::*;
#(
    parameter  int DATA_WIDTH  = ITREE_DATA_W,
    parameter  int TREE_DEPTH  = 4,
    parameter  int ADJ_W       = ITREE_ADJ_W,
    parameter  int ANOMALY_LEN = 3,
    localparam int NODE_COUNT  = node_count(TREE_DEPTH),
    localparam int ADDR_W      = addr_w(TREE_DEPTH),
    localparam int PATH_W      = path_w(TREE_DEPTH, ADJ_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_ready,
    output logic                  data_processed,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_threshold,
    input  logic                  cfg_leaf,
    input  logic [ADJ_W-1:0]      cfg_adj,
    output logic                  cfg_reject,
    output logic                  score_valid,
    output logic [PATH_W-1:0]     path_length,
    output logic                  anomaly,
    output logic                  busy,
    output logic                  overrun
);

    localparam int DEPTH_W = $clog2(TREE_DEPTH + 1);

    // NODE_COUNT is always 2^ADDR_W - 1, so the last legal address fits in ADDR_W bits.
    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(NODE_COUNT - 1);
    localparam logic [DEPTH_W-1:0] MAX_DEPTH   = DEPTH_W'(TREE_DEPTH);
    localparam logic [PATH_W-1:0]  ANOMALY_MAX = PATH_W'(ANOMALY_LEN);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic [ADDR_W-1:0]       idx_q;
    logic [DEPTH_W-1:0]      depth_q;

    node_t                   node;
    node_t                   wr_node;
    logic                    table_we;
    logic                    at_leaf;
    logic [PATH_W-1:0]       leaf_path;
    logic [ADDR_W-1:0]       child_idx;

    // The write commits on the same edge that accepts a sample, so the walk
    // that starts on the next cycle already sees the updated entry.
    assign table_we = cfg_we && (state_q == IDLE) && (cfg_addr <= LAST_ADDR);

    always_comb begin
        wr_node           = '0;
        wr_node.threshold = cfg_threshold;
        wr_node.leaf      = cfg_leaf;
        wr_node.adj       = cfg_adj;
    end

    itree_node_table #(
        .NODE_COUNT (NODE_COUNT),
        .ADDR_W     (ADDR_W)
    ) u_node_table (
        .clk     (clk),
        .reset   (reset),
        .we      (table_we),
        .wr_addr (cfg_addr),
        .wr_node (wr_node),
        .rd_addr (idx_q),
        .rd_node (node)
    );

    assign at_leaf   = node.leaf || (depth_q == MAX_DEPTH);
    assign leaf_path = PATH_W'(depth_q) + PATH_W'(node.adj);

    // Children of node i are 2i+1 (left, sample < threshold) and 2i+2 (right).
    // This is only used below MAX_DEPTH, where the dropped top bit of idx is zero.
    assign child_idx = {idx_q[ADDR_W-2:0], 1'b0}
                     + ((sample_q < node.threshold) ? ADDR_W'(1) : ADDR_W'(2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            sample_q       <= '0;
            idx_q          <= '0;
            depth_q        <= '0;
            score_valid    <= 1'b0;
            data_processed <= 1'b0;
            path_length    <= '0;
            anomaly        <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            cfg_reject     <= 1'b0;
        end else begin
            score_valid    <= 1'b0;
            data_processed <= 1'b0;
            cfg_reject     <= cfg_we && ((state_q != IDLE) || (cfg_addr > LAST_ADDR));

            case (state_q)
                IDLE: begin
                    if (data_ready) begin
                        sample_q <= data_in;
                        idx_q    <= '0;
                        depth_q  <= '0;
                        busy     <= 1'b1;
                        state_q  <= WALK;
                    end
                end
                WALK: begin
                    if (data_ready) begin
                        overrun <= 1'b1;
                    end
                    if (at_leaf) begin
                        path_length    <= leaf_path;
                        anomaly        <= (leaf_path <= ANOMALY_MAX);
                        score_valid    <= 1'b1;
                        data_processed <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        idx_q   <= child_idx;
                        depth_q <= depth_q + DEPTH_W'(1);
                    end
                end
                DONE: begin
                    if (data_ready) begin
                        overrun <= 1'b1;
                    end
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isolation_tree_scorer.sv
// Self-checking bench for isolation_tree_scorer at its default parameters.
// A reference tree model predicts path length, anomaly and latency for each
// sample. The prediction is queued when the sample is driven, then popped
// and compared when score_valid appears.
module tb_isolation_tree_scorer;

    localparam int NODES = 31;
    localparam int D     = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_ready = 1'b0;
    logic       data_processed;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [7:0] cfg_threshold = '0;
    logic       cfg_leaf = 1'b0;
    logic [3:0] cfg_adj = '0;
    logic       cfg_reject;
    logic       score_valid;
    logic [4:0] path_length;
    logic       anomaly;
    logic       busy;
    logic       overrun;

    isolation_tree_scorer dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .data_ready     (data_ready),
        .data_processed (data_processed),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_threshold  (cfg_threshold),
        .cfg_leaf       (cfg_leaf),
        .cfg_adj        (cfg_adj),
        .cfg_reject     (cfg_reject),
        .score_valid    (score_valid),
        .path_length    (path_length),
        .anomaly        (anomaly),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int dp_count = 0;
    int sv_count = 0;

    always @(negedge clk) begin
        if (data_processed === 1'b1) dp_count++;
        if (score_valid === 1'b1) sv_count++;
    end

    // Reference model of the node table and walk.
    int m_thr  [NODES];
    bit m_leaf [NODES];
    int m_adj  [NODES];

    typedef struct {
        int path;
        bit anom;
        int lat;
    } exp_t;
    exp_t sb[$];

    function automatic void model_clear();
        for (int i = 0; i < NODES; i++) begin
            m_thr[i] = 0; m_leaf[i] = 0; m_adj[i] = 0;
        end
    endfunction

    function automatic void push_expect(input int s);
        exp_t e;
        int idx = 0;
        for (int d = 0; d <= D; d++) begin
            if (m_leaf[idx] || d == D) begin
                e.path = d + m_adj[idx];
                e.anom = (e.path <= 3);
                e.lat  = d + 2;
                break;
            end
            idx = (s < m_thr[idx]) ? 2 * idx + 1 : 2 * idx + 2;
        end
        sb.push_back(e);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic cfg_write(input int a, input int thr, input bit lf, input int adj, output bit rej);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_threshold = 8'(thr); cfg_leaf = lf; cfg_adj = 4'(adj);
        @(negedge clk);
        cfg_we = 1'b0;
        rej = cfg_reject;
        if (a < NODES) begin
            m_thr[a] = thr; m_leaf[a] = lf; m_adj[a] = adj;
        end
    endtask

    // Drives one sample, optionally with a simultaneous config write, and waits
    // (bounded) for score_valid. lat counts cycles from the data_ready cycle (0).
    task automatic send_and_wait(input int s, input bit with_cfg, input int a, input int thr,
                                 input bit lf, input int adj,
                                 output bit seen, output int lat, output int path, output bit anom);
        @(negedge clk);
        data_in = 8'(s); data_ready = 1'b1;
        if (with_cfg) begin
            cfg_we = 1'b1; cfg_addr = 5'(a); cfg_threshold = 8'(thr); cfg_leaf = lf; cfg_adj = 4'(adj);
        end
        @(negedge clk);
        data_ready = 1'b0; cfg_we = 1'b0;
        lat = 1; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (score_valid === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        path = int'(path_length);
        anom = anomaly;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({score_valid, data_processed, cfg_reject, busy, overrun, anomaly, path_length} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got sv=%b dp=%b rej=%b busy=%b ovr=%b anom=%b path=%0d, want all 0",
                     score_valid, data_processed, cfg_reject, busy, overrun, anomaly, path_length);
        end
        reset = 1'b1;
        model_clear();
    endtask

    task automatic score_one(input string name, input int s);
        bit seen; int lat; int path; bit anom; exp_t e; int dp0;
        dp0 = dp_count;
        push_expect(s);
        send_and_wait(s, 0, 0, 0, 0, 0, seen, lat, path, anom);
        e = sb.pop_front();
        total++;
        if (!seen || lat != e.lat || path != e.path || anom != e.anom) begin
            bad++;
            $display("FAIL %s: got seen=%0b lat=%0d path=%0d anom=%0b, want lat=%0d path=%0d anom=%0b",
                     name, seen, lat, path, anom, e.lat, e.path, e.anom);
        end
        total++;
        if (dp_count - dp0 != 1) begin
            bad++;
            $display("FAIL %s_dp_pulses: got %0d, want 1", name, dp_count - dp0);
        end
    endtask

    task automatic test_post_reset_default();
        score_one("default_5a", 'h5A);
    endtask

    task automatic test_root_leaf();
        bit rej;
        cfg_write(0, 0, 1, 2, rej);
        total++;
        if (rej !== 1'b0) begin
            bad++;
            $display("FAIL root_cfg_reject: got %b, want 0", rej);
        end
        score_one("root_leaf_10", 'h10);
    endtask

    task automatic test_split();
        bit rej;
        do_reset();
        cfg_write(0, 'h80, 0, 0, rej);
        cfg_write(1, 0, 1, 0, rej);
        cfg_write(2, 'hC0, 0, 0, rej);
        cfg_write(6, 0, 1, 5, rej);
        score_one("split_20", 'h20);
        score_one("split_f0", 'hF0);
        score_one("split_eq_80", 'h80);
    endtask

    task automatic test_overrun();
        int first_sv; int sv0;
        exp_t e;
        do_reset();
        sv0 = sv_count;
        first_sv = -1;
        @(negedge clk);
        data_in = 8'h5A; data_ready = 1'b1;
        push_expect('h5A);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            data_ready = 1'b0;
            if (c == 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_cycle1: got %b, want 1", busy);
                end
            end
            if (c == 3) begin
                total++;
                if (overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL overrun_before: got %b, want 0", overrun);
                end
                data_in = 8'h33; data_ready = 1'b1;
            end
            if (c == 4) begin
                total++;
                if (overrun !== 1'b1) begin
                    bad++;
                    $display("FAIL overrun_rise: got %b, want 1", overrun);
                end
            end
            if (score_valid === 1'b1 && first_sv < 0) first_sv = c;
        end
        e = sb.pop_front();
        total++;
        if (first_sv != e.lat || sv_count - sv0 != 1) begin
            bad++;
            $display("FAIL overrun_single_score: got first=%0d count=%0d, want first=%0d count=1",
                     first_sv, sv_count - sv0, e.lat);
        end
        total++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun_sticky: got ovr=%b busy=%b, want ovr=1 busy=0", overrun, busy);
        end
    endtask

    task automatic test_cfg_reject();
        bit rej; bit seen; int lat; int path; bit anom; exp_t e;
        do_reset();
        @(negedge clk);
        data_in = 8'h44; data_ready = 1'b1;
        push_expect('h44);
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_threshold = 8'h00; cfg_leaf = 1'b1; cfg_adj = 4'd2;
        @(negedge clk);
        cfg_we = 1'b0;
        total++;
        if (cfg_reject !== 1'b1) begin
            bad++;
            $display("FAIL reject_walk_pulse: got %b, want 1", cfg_reject);
        end
        @(negedge clk);
        total++;
        if (cfg_reject !== 1'b0) begin
            bad++;
            $display("FAIL reject_walk_clear: got %b, want 0", cfg_reject);
        end
        repeat (4) @(negedge clk);
        void'(sb.pop_front());
        score_one("after_walk_reject", 'h44);

        cfg_write(31, 0, 1, 1, rej);
        total++;
        if (rej !== 1'b1) begin
            bad++;
            $display("FAIL reject_addr31: got %b, want 1", rej);
        end
        score_one("after_addr31", 'h01);

        m_thr[0] = 0; m_leaf[0] = 1; m_adj[0] = 1;
        push_expect('h99);
        send_and_wait('h99, 1, 0, 0, 1, 1, seen, lat, path, anom);
        e = sb.pop_front();
        total++;
        if (!seen || lat != e.lat || path != e.path || anom != e.anom) begin
            bad++;
            $display("FAIL simul_cfg_sample: got seen=%0b lat=%0d path=%0d anom=%0b, want lat=%0d path=%0d anom=%0b",
                     seen, lat, path, anom, e.lat, e.path, e.anom);
        end
    endtask

    task automatic test_reset_mid_walk();
        bit rej; int dp0;
        do_reset();
        cfg_write(0, 0, 1, 2, rej);
        cfg_write(0, 0, 0, 0, rej);
        cfg_write(2, 0, 1, 6, rej);
        dp0 = dp_count;
        @(negedge clk);
        data_in = 8'h77; data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({score_valid, data_processed, cfg_reject, busy, overrun, anomaly, path_length} !== '0) begin
            bad++;
            $display("FAIL midwalk_reset_outputs: got sv=%b dp=%b busy=%b path=%0d, want all 0",
                     score_valid, data_processed, busy, path_length);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_clear();
        repeat (6) @(negedge clk);
        total++;
        if (dp_count != dp0) begin
            bad++;
            $display("FAIL midwalk_no_dp: got %0d pulses, want 0", dp_count - dp0);
        end
        score_one("after_midwalk_reset", 'h77);
    endtask

    task automatic test_back_to_back();
        bit rej;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cfg_write(i, $urandom_range(255), ($urandom_range(3) == 0), $urandom_range(15), rej);
        end
        for (int i = 0; i < 8; i++) begin
            score_one($sformatf("b2b_%0d", i), $urandom_range(255));
        end
    endtask

    initial begin
        test_reset();
        test_post_reset_default();
        test_root_leaf();
        test_split();
        test_overrun();
        test_cfg_reject();
        test_reset_mid_walk();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
